rf_write_scheduler: RTL and testbench

//  Schedules the single write port of the 16x32 register file between two writeback requesters:

---
 rtl/rf_write_scheduler_if.sv | 35 +++
 rtl/rf_write_scheduler.sv | 99 +++++++++
 tb/tb_rf_write_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_scheduler_if.sv
// Writeback bus between the two requesters (ALU, load unit) and the register file write scheduler.
// Handshake: a request transfers on a CLK posedge where x_VALID && x_READY; x_READY depends on FIFO state only.
interface rf_write_scheduler_if #(
   parameter int DW    = 32,
   parameter int AW    = 4,
   parameter int DEPTH = 2
);
   localparam int PCW = $clog2(2 * DEPTH + 1);

   logic           A_VALID;
   logic           A_READY;
   logic [AW-1:0]  A_REG;
   logic [DW-1:0]  A_DATA;
   logic           B_VALID;
   logic           B_READY;
   logic [AW-1:0]  B_REG;
   logic [DW-1:0]  B_DATA;
   logic [AW-1:0]  RF_DREG;
   logic           RF_RFLD;
   logic [DW-1:0]  RF_DATA;
   logic           R0_DROP;
   logic [PCW-1:0] PENDING;
   logic           IDLE;
   logic           LAST_DBG;   // arbiter state: 0 = A granted last, 1 = B granted last

   modport master (
      output A_VALID, A_REG, A_DATA, B_VALID, B_REG, B_DATA,
      input  A_READY, B_READY, RF_DREG, RF_RFLD, RF_DATA, R0_DROP, PENDING, IDLE, LAST_DBG
   );

   modport slave (
      input  A_VALID, A_REG, A_DATA, B_VALID, B_REG, B_DATA,
      output A_READY, B_READY, RF_DREG, RF_RFLD, RF_DATA, R0_DROP, PENDING, IDLE, LAST_DBG
   );
endinterface

// File: rtl/rf_write_scheduler.sv
// Round-robin scheduler sharing the register file write port between the ALU (A) and load (B)
// writeback requesters, each buffered by a small FIFO; the RF bus is driven from registers.
module rf_write_scheduler #(
   parameter int DW    = 32,
   parameter int AW    = 4,
   parameter int DEPTH = 2
) (
   input logic                CLK,
   input logic                RESET_N,
   rf_write_scheduler_if.slave bus
);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int PCW = $clog2(2 * DEPTH + 1);
   localparam int EW  = AW + DW;

   typedef enum logic {
      LAST_A = 1'b0,
      LAST_B = 1'b1
   } last_t;

   last_t          last;
   logic [EW-1:0]  a_mem [DEPTH];
   logic [EW-1:0]  b_mem [DEPTH];
   logic [PW-1:0]  a_wp, a_rp, b_wp, b_rp;
   logic [CW-1:0]  a_cnt, b_cnt;
   logic [AW-1:0]  rf_dreg;
   logic [DW-1:0]  rf_data;
   logic           rf_rfld;
   logic           r0_drop;

   logic           a_full, b_full, a_ne, b_ne;
   logic           a_push, b_push, gnt_a, gnt_b;
   logic [EW-1:0]  head;
   logic [AW-1:0]  head_reg;

   assign a_full = (a_cnt == CW'(DEPTH));
   assign b_full = (b_cnt == CW'(DEPTH));
   assign a_ne   = (a_cnt != '0);
   assign b_ne   = (b_cnt != '0);
   assign a_push = bus.A_VALID && !a_full;
   assign b_push = bus.B_VALID && !b_full;

   // Contention goes to the port that did not win last time.
   assign gnt_a    = a_ne && (!b_ne || (last == LAST_B));
   assign gnt_b    = b_ne && (!a_ne || (last == LAST_A));
   assign head     = gnt_a ? a_mem[a_rp] : b_mem[b_rp];
   assign head_reg = head[EW-1:DW];

   always_ff @(posedge CLK) begin
      if (a_push) a_mem[a_wp] <= {bus.A_REG, bus.A_DATA};
      if (b_push) b_mem[b_wp] <= {bus.B_REG, bus.B_DATA};
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         last    <= LAST_B;
         a_wp    <= '0;
         a_rp    <= '0;
         b_wp    <= '0;
         b_rp    <= '0;
         a_cnt   <= '0;
         b_cnt   <= '0;
         rf_dreg <= '0;
         rf_data <= '0;
         rf_rfld <= 1'b0;
         r0_drop <= 1'b0;
      end else begin
         if (a_push) a_wp <= a_wp + PW'(1);
         if (b_push) b_wp <= b_wp + PW'(1);
         if (gnt_a)  a_rp <= a_rp + PW'(1);
         if (gnt_b)  b_rp <= b_rp + PW'(1);
         a_cnt <= a_cnt + CW'(a_push) - CW'(gnt_a);
         b_cnt <= b_cnt + CW'(b_push) - CW'(gnt_b);

         if (gnt_a || gnt_b) begin
            last    <= gnt_a ? LAST_A : LAST_B;
            rf_dreg <= head_reg;
            rf_data <= head[DW-1:0];
            // R0 is hardwired: the entry is consumed but never reaches the register file.
            rf_rfld <= (head_reg != '0);
            r0_drop <= (head_reg == '0);
         end else begin
            rf_rfld <= 1'b0;
            r0_drop <= 1'b0;
         end
      end
   end

   assign bus.A_READY  = !a_full;
   assign bus.B_READY  = !b_full;
   assign bus.RF_DREG  = rf_dreg;
   assign bus.RF_DATA  = rf_data;
   assign bus.RF_RFLD  = rf_rfld;
   assign bus.R0_DROP  = r0_drop;
   assign bus.PENDING  = PCW'(a_cnt) + PCW'(b_cnt);
   assign bus.IDLE     = (a_cnt == '0) && (b_cnt == '0) && !rf_rfld;
   assign bus.LAST_DBG = last;
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: scenario tasks with per-port expected queues
// matched against the writes observed on the register file port.
module tb_rf_write_scheduler;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int DEPTH = 2;
   localparam int EW = AW + DW;

   logic CLK;
   logic RESET_N;

   rf_write_scheduler_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

   rf_write_scheduler #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;
   int drop_cnt = 0;

   logic [EW-1:0] exp_a_q[$];
   logic [EW-1:0] exp_b_q[$];
   logic [EW-1:0] obs_q[$];
   logic [EW-1:0] obs_a_q[$];
   logic [EW-1:0] obs_b_q[$];

   // monitor: records every register file write and every R0 drop
   always @(negedge CLK) begin
      if (RESET_N) begin
         if (bus.RF_RFLD) obs_q.push_back({bus.RF_DREG, bus.RF_DATA});
         if (bus.R0_DROP) drop_cnt++;
      end
   end

   task automatic wait_neg();
      @(negedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.A_VALID = 1'b0;
      bus.A_REG   = '0;
      bus.A_DATA  = '0;
      bus.B_VALID = 1'b0;
      bus.B_REG   = '0;
      bus.B_DATA  = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RESET_N = 1'b0;
      #3;
      exp_a_q.delete();
      exp_b_q.delete();
      obs_q.delete();
      wait_neg();
      drop_cnt = 0;
      RESET_N = 1'b1;
   endtask

   // sort observed writes into per-port queues by the data tag nibble
   task automatic split_obs();
      obs_a_q.delete();
      obs_b_q.delete();
      foreach (obs_q[i]) begin
         if (obs_q[i][DW-1:DW-4] == 4'hA) obs_a_q.push_back(obs_q[i]);
         else obs_b_q.push_back(obs_q[i]);
      end
   endtask

   // drive one cycle: present requests, record those the DUT will accept at the next posedge
   task automatic drive_cycle(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                              input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                              output logic a_acc, output logic b_acc);
      bus.A_VALID = av;
      bus.A_REG   = ar;
      bus.A_DATA  = ad;
      bus.B_VALID = bv;
      bus.B_REG   = br;
      bus.B_DATA  = bd;
      a_acc = av && bus.A_READY;
      b_acc = bv && bus.B_READY;
      if (a_acc) exp_a_q.push_back({ar, ad});
      if (b_acc) exp_b_q.push_back({br, bd});
   endtask

   task automatic drain(input int max_cycles, input int total);
      idle_inputs();
      for (int i = 0; i < max_cycles; i++) begin
         if (obs_q.size() >= total && bus.IDLE) break;
         wait_neg();
      end
      wait_neg();
   endtask

   task automatic test_reset();
      logic aa, ba;
      do_reset();
      drive_cycle(1'b1, 4'd5, 32'hA000_0055, 1'b1, 4'd6, 32'hB000_0066, aa, ba);
      wait_neg();
      idle_inputs();
      wait_neg();
      n_checks++;
      if (bus.RF_RFLD !== 1'b1) begin
         n_errors++; $display("FAIL pre_reset_rfld: got %b want 1", bus.RF_RFLD);
      end
      #2;
      RESET_N = 1'b0;
      #1;
      n_checks++;
      if (bus.RF_RFLD !== 1'b0 || bus.RF_DREG !== '0 || bus.RF_DATA !== '0 || bus.R0_DROP !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: rfld=%b dreg=%h data=%h drop=%b want all 0",
                  bus.RF_RFLD, bus.RF_DREG, bus.RF_DATA, bus.R0_DROP);
      end
      n_checks++;
      if (bus.PENDING !== '0 || bus.IDLE !== 1'b1) begin
         n_errors++; $display("FAIL reset_status: pending=%0d idle=%b want 0/1", bus.PENDING, bus.IDLE);
      end
      n_checks++;
      if (bus.A_READY !== 1'b1 || bus.B_READY !== 1'b1 || bus.LAST_DBG !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_ready: a_ready=%b b_ready=%b last=%b want 1/1/1",
                  bus.A_READY, bus.B_READY, bus.LAST_DBG);
      end
      do_reset();
   endtask

   task automatic test_single_write();
      logic aa, ba;
      do_reset();
      drive_cycle(1'b1, 4'd3, 32'h0000_1234, 1'b0, '0, '0, aa, ba);
      n_checks++;
      if (aa !== 1'b1) begin
         n_errors++; $display("FAIL single_accept: got %b want 1", aa);
      end
      wait_neg();
      idle_inputs();
      n_checks++;
      if (bus.RF_RFLD !== 1'b0 || bus.PENDING !== 3'd1) begin
         n_errors++; $display("FAIL single_latency: rfld=%b pending=%0d want 0/1", bus.RF_RFLD, bus.PENDING);
      end
      wait_neg();
      n_checks++;
      if (bus.RF_RFLD !== 1'b1 || bus.RF_DREG !== 4'd3 || bus.RF_DATA !== 32'h0000_1234) begin
         n_errors++;
         $display("FAIL single_write: rfld=%b dreg=%0d data=%h want 1/3/00001234",
                  bus.RF_RFLD, bus.RF_DREG, bus.RF_DATA);
      end
      wait_neg();
      n_checks++;
      if (bus.RF_RFLD !== 1'b0 || bus.IDLE !== 1'b1 || bus.RF_DREG !== 4'd3) begin
         n_errors++;
         $display("FAIL single_after: rfld=%b idle=%b dreg=%0d want 0/1/3", bus.RF_RFLD, bus.IDLE, bus.RF_DREG);
      end
      n_checks++;
      if (obs_q.size() != 1) begin
         n_errors++; $display("FAIL single_count: got %0d writes want 1", obs_q.size());
      end
   endtask

   task automatic test_back_to_back();
      logic aa, ba;
      int ai, bi, total, pairs;
      do_reset();
      ai = 0;
      bi = 0;
      for (int c = 0; c < 10; c++) begin
         drive_cycle(1'b1, AW'(1 + ai % 7), 32'hA000_0000 + ai, 1'b1, AW'(8 + bi % 7), 32'hB000_0000 + bi, aa, ba);
         if (aa) ai++;
         if (ba) bi++;
         wait_neg();
      end
      total = ai + bi;
      drain(40, total);
      n_checks++;
      if (obs_q.size() != total) begin
         n_errors++; $display("FAIL b2b_count: got %0d writes want %0d", obs_q.size(), total);
      end
      pairs = (ai < bi) ? ai : bi;
      for (int i = 0; i < 2 * pairs && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i][DW-1:DW-4] !== ((i % 2 == 0) ? 4'hA : 4'hB)) begin
            n_errors++;
            $display("FAIL b2b_alternate[%0d]: got tag %h want %h", i, obs_q[i][DW-1:DW-4],
                     (i % 2 == 0) ? 4'hA : 4'hB);
         end
      end
      split_obs();
      while (exp_a_q.size() > 0) begin
         logic [EW-1:0] e;
         e = exp_a_q.pop_front();
         n_checks++;
         if (obs_a_q.size() == 0) begin
            n_errors++; $display("FAIL b2b_port_a: missing entry want %h", e);
         end else if (obs_a_q[0] !== e) begin
            n_errors++; $display("FAIL b2b_port_a: got %h want %h", obs_a_q[0], e);
            void'(obs_a_q.pop_front());
         end else void'(obs_a_q.pop_front());
      end
      while (exp_b_q.size() > 0) begin
         logic [EW-1:0] e;
         e = exp_b_q.pop_front();
         n_checks++;
         if (obs_b_q.size() == 0) begin
            n_errors++; $display("FAIL b2b_port_b: missing entry want %h", e);
         end else if (obs_b_q[0] !== e) begin
            n_errors++; $display("FAIL b2b_port_b: got %h want %h", obs_b_q[0], e);
            void'(obs_b_q.pop_front());
         end else void'(obs_b_q.pop_front());
      end
   endtask

   task automatic test_fill();
      logic aa, ba;
      int ai, bi, max_pend;
      logic a_blocked, b_blocked;
      logic [DW-1:0] ad, bd;
      do_reset();
      ai = 0;
      bi = 0;
      max_pend = 0;
      a_blocked = 1'b0;
      b_blocked = 1'b0;
      ad = {8'hA0, 24'($urandom_range(0, 32'hFF_FFFF))};
      bd = {8'hB0, 24'($urandom_range(0, 32'hFF_FFFF))};
      for (int c = 0; c < 100 && (ai < 6 || bi < 6); c++) begin
         if (!bus.A_READY) a_blocked = 1'b1;
         if (!bus.B_READY) b_blocked = 1'b1;
         drive_cycle(ai < 6, AW'(1 + ai), ad, bi < 6, AW'(7 + bi), bd, aa, ba);
         if (aa) begin
            ai++;
            ad = {8'hA0, 24'($urandom_range(0, 32'hFF_FFFF))};
         end
         if (ba) begin
            bi++;
            bd = {8'hB0, 24'($urandom_range(0, 32'hFF_FFFF))};
         end
         wait_neg();
         if (int'(bus.PENDING) > max_pend) max_pend = int'(bus.PENDING);
      end
      drain(40, 12);
      n_checks++;
      if (ai != 6 || bi != 6) begin
         n_errors++; $display("FAIL fill_accepts: got a=%0d b=%0d want 6/6", ai, bi);
      end
      n_checks++;
      if (max_pend > 2 * DEPTH || max_pend < 2) begin
         n_errors++; $display("FAIL fill_pending: max %0d want 2..%0d", max_pend, 2 * DEPTH);
      end
      n_checks++;
      if (!(a_blocked || b_blocked)) begin
         n_errors++; $display("FAIL fill_backpressure: ready never low, want some low");
      end
      n_checks++;
      if (obs_q.size() != 12) begin
         n_errors++; $display("FAIL fill_count: got %0d writes want 12", obs_q.size());
      end
      split_obs();
      while (exp_a_q.size() > 0) begin
         logic [EW-1:0] e;
         e = exp_a_q.pop_front();
         n_checks++;
         if (obs_a_q.size() == 0) begin
            n_errors++; $display("FAIL fill_port_a: missing entry want %h", e);
         end else if (obs_a_q[0] !== e) begin
            n_errors++; $display("FAIL fill_port_a: got %h want %h", obs_a_q[0], e);
            void'(obs_a_q.pop_front());
         end else void'(obs_a_q.pop_front());
      end
      while (exp_b_q.size() > 0) begin
         logic [EW-1:0] e;
         e = exp_b_q.pop_front();
         n_checks++;
         if (obs_b_q.size() == 0) begin
            n_errors++; $display("FAIL fill_port_b: missing entry want %h", e);
         end else if (obs_b_q[0] !== e) begin
            n_errors++; $display("FAIL fill_port_b: got %h want %h", obs_b_q[0], e);
            void'(obs_b_q.pop_front());
         end else void'(obs_b_q.pop_front());
      end
      n_checks++;
      if (obs_a_q.size() + obs_b_q.size() != 0) begin
         n_errors++; $display("FAIL fill_extra: got %0d unexpected writes want 0", obs_a_q.size() + obs_b_q.size());
      end
   endtask

   task automatic test_r0_drop();
      logic aa, ba;
      do_reset();
      drive_cycle(1'b0, '0, '0, 1'b1, 4'd0, 32'hFFFF_FFFF, aa, ba);
      wait_neg();
      idle_inputs();
      wait_neg();
      n_checks++;
      if (bus.R0_DROP !== 1'b1 || bus.RF_RFLD !== 1'b0) begin
         n_errors++; $display("FAIL r0_pulse: drop=%b rfld=%b want 1/0", bus.R0_DROP, bus.RF_RFLD);
      end
      wait_neg();
      n_checks++;
      if (bus.R0_DROP !== 1'b0 || bus.RF_RFLD !== 1'b0 || bus.IDLE !== 1'b1) begin
         n_errors++;
         $display("FAIL r0_after: drop=%b rfld=%b idle=%b want 0/0/1", bus.R0_DROP, bus.RF_RFLD, bus.IDLE);
      end
      n_checks++;
      if (drop_cnt != 1 || obs_q.size() != 0) begin
         n_errors++; $display("FAIL r0_counts: drops=%0d writes=%0d want 1/0", drop_cnt, obs_q.size());
      end
   endtask

   task automatic test_reset_flush();
      logic aa, ba;
      do_reset();
      drive_cycle(1'b1, 4'd2, 32'hA000_0002, 1'b1, 4'd9, 32'hB000_0009, aa, ba);
      wait_neg();
      drive_cycle(1'b1, 4'd4, 32'hA000_0004, 1'b0, '0, '0, aa, ba);
      wait_neg();
      idle_inputs();
      n_checks++;
      if (bus.RF_RFLD !== 1'b1 || bus.PENDING !== 3'd2) begin
         n_errors++; $display("FAIL flush_pre: rfld=%b pending=%0d want 1/2", bus.RF_RFLD, bus.PENDING);
      end
      RESET_N = 1'b0;
      #1;
      n_checks++;
      if (bus.RF_RFLD !== 1'b0 || bus.PENDING !== '0 || bus.IDLE !== 1'b1) begin
         n_errors++;
         $display("FAIL flush_reset: rfld=%b pending=%0d idle=%b want 0/0/1", bus.RF_RFLD, bus.PENDING, bus.IDLE);
      end
      wait_neg();
      obs_q.delete();
      RESET_N = 1'b1;
      for (int i = 0; i < 8; i++) wait_neg();
      n_checks++;
      if (obs_q.size() != 0 || bus.PENDING !== '0) begin
         n_errors++; $display("FAIL flush_after: writes=%0d pending=%0d want 0/0", obs_q.size(), bus.PENDING);
      end
   endtask

   initial begin
      RESET_N = 1'b0;
      idle_inputs();
      repeat (2) @(posedge CLK);
      wait_neg();
      RESET_N = 1'b1;
      wait_neg();
      test_reset();
      test_single_write();
      test_back_to_back();
      test_fill();
      test_r0_drop();
      test_reset_flush();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
